// File: rtl/adder_result_buffer.sv
// rtl/adder_result_buffer.sv - FIFO buffer for adder {cout,sum} results with optional carry counter
//
// Purpose: buffers DEPTH adder results in order. The head entry is exposed
// on out_sum/out_cout, and outputs read zero while the buffer is empty.
// Optional feature macro: ADDER_RESULT_BUFFER_CARRY_CNT_EN enables carry_cnt.
// Without it, carry_cnt is tied to 0.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   upstream result present
//   in_ready   buffer can accept (count < DEPTH)
//   in_sum     adder sum, WIDTH bits
//   in_cout    adder carry-out
//   out_valid  head entry present (count != 0)
//   out_ready  consumer takes head entry
//   out_sum    head sum (0 when empty)
//   out_cout   head carry-out (0 when empty)
//   count      occupancy, $clog2(DEPTH)+1 bits
//   carry_cnt  saturating count of accepted entries with in_cout=1

module adder_result_buffer #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_sum,
    input  logic                     in_cout,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_sum,
    output logic                     out_cout,
    output logic [$clog2(DEPTH):0]   count,
    output logic [7:0]               carry_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    logic [WIDTH:0]  mem [DEPTH];
    logic [AW-1:0]   head;
    logic [AW-1:0]   tail;
    logic            push;
    logic            pop;

    // Readiness depends only on registered occupancy, so a pop in the
    // same cycle never opens a slot while the buffer is full.
    assign in_ready  = (count < FULL_LVL);
    assign out_valid = (count != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    assign {out_cout, out_sum} = out_valid ? mem[head] : '0;

    // DEPTH is a power of two, so natural pointer overflow is the modulo wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage is not reset; entries are discarded by clearing the pointers.
    always_ff @(posedge clk) begin
        if (push && !rst) mem[tail] <= {in_cout, in_sum};
    end

`ifdef ADDER_RESULT_BUFFER_CARRY_CNT_EN
    logic [7:0] carry_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            carry_q <= '0;
        end else if (push && in_cout && (carry_q != 8'hff)) begin
            carry_q <= carry_q + 8'd1;
        end
    end

    assign carry_cnt = carry_q;
`else
    assign carry_cnt = '0;
`endif

endmodule

// File: doc/adder_result_buffer.md
ADDER_RESULT_BUFFER -- requirements
Module: adder_result_buffer

Interface
REQ-001 SHALL have parameter WIDTH, default 4: bit width of the sum field, matching the upstream adder's WIDTH.
REQ-002 SHALL have parameter DEPTH, default 4: number of result entries; legal values are powers of two from 2 to 16.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1 bit: upstream result present on in_sum/in_cout.
REQ-006 SHALL have port in_ready, output, 1 bit: buffer can accept an entry this cycle.
REQ-007 SHALL have port in_sum, input, WIDTH bits: adder sum.
REQ-008 SHALL have port in_cout, input, 1 bit: adder carry-out.
REQ-009 SHALL have port out_valid, output, 1 bit: head entry present.
REQ-010 SHALL have port out_ready, input, 1 bit: consumer takes head entry.
REQ-011 SHALL have port out_sum, output, WIDTH bits: head sum.
REQ-012 SHALL have port out_cout, output, 1 bit: head carry-out.
REQ-013 SHALL have port count, output, $clog2(DEPTH)+1 bits: current occupancy.
REQ-014 SHALL have port carry_cnt, output, 8 bits: saturating count of accepted entries with in_cout=1.

Function
REQ-015 SHALL perform a push when in_valid=1 and in_ready=1 at a rising clk edge, storing {in_cout,in_sum} at the tail.
REQ-016 SHALL perform a pop when out_valid=1 and out_ready=1 at a rising clk edge, advancing the head.
REQ-017 SHALL drive in_ready = (count < DEPTH), combinationally from registered state only, with no dependency on out_ready.
REQ-018 SHALL drive out_valid = (count != 0).
REQ-019 SHALL present a pushed entry on out_sum/out_cout with out_valid=1 one cycle after the push edge when the buffer was empty; there is no same-cycle pass-through.
REQ-020 SHALL drive out_sum=0 and out_cout=0 whenever out_valid=0.
REQ-021 SHALL hold out_sum/out_cout stable while out_valid=1 and out_ready=0.
REQ-022 SHALL change count as follows: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
REQ-023 SHALL accept a simultaneous push and pop whenever count is between 1 and DEPTH-1 inclusive.
REQ-024 SHALL, when full (count=DEPTH), hold in_ready=0 and ignore in_valid even if a pop occurs in the same cycle.
REQ-025 SHALL, when empty, ignore out_ready.
REQ-026 SHALL wrap head and tail pointers modulo DEPTH with no gap or duplicate entry.
REQ-027 SHALL preserve entry order (first in, first out), bit-exact for all WIDTH+1 bits.
REQ-028 SHALL increment carry_cnt by 1 on each push with in_cout=1, saturating at 255; it never wraps and pops do not affect it.

Reset
REQ-029 SHALL, on rst=1 (asynchronous assert, including mid-transfer), clear pointers, count and carry_cnt to 0 and force out_valid=0, out_sum=0, out_cout=0 and in_ready=1 immediately.
REQ-030 SHALL discard stored entries on reset, and SHALL perform no push or pop on the first rising edge at which rst is 1.
REQ-031 SHALL accept its first push on the first rising clk edge after rst deasserts.

Configuration
REQ-032 SHALL use the macro ADDER_RESULT_BUFFER_CARRY_CNT_EN to control the carry counter.
REQ-033 SHALL, with ADDER_RESULT_BUFFER_CARRY_CNT_EN defined, implement carry_cnt per REQ-028.
REQ-034 SHALL, without ADDER_RESULT_BUFFER_CARRY_CNT_EN defined, tie carry_cnt to constant 0 with no counter register; all other behaviour is identical.

Verification
REQ-035 Bench SHALL cover single push: WIDTH=4, push sum=4'b0000 cout=1 into an empty buffer -> next cycle out_valid=1, out_sum=0000, out_cout=1, count=1, carry_cnt=1.
REQ-036 Bench SHALL cover fill and stall: DEPTH=4, push 0010, 0000, 1111, 1110 with out_ready=0 -> count=4, in_ready=0; a fifth push is ignored; draining yields the four entries in push order.
REQ-037 Bench SHALL cover simultaneous push and pop: count=2 with in_valid=1 and out_ready=1 for 10 cycles -> count stays 2 and output order is preserved across a pointer wrap.
REQ-038 Bench SHALL cover full plus pop: count=4 with in_valid=1 and out_ready=1 -> pop only, count=3 next cycle, in_ready=1.
REQ-039 Bench SHALL cover carry saturation: 300 pushes with cout=1 and concurrent drain -> carry_cnt=255; with the macro undefined, carry_cnt=0 throughout.
REQ-040 Bench SHALL cover mid-operation reset: assert rst asynchronously between edges at count=3 -> out_valid=0, count=0 and carry_cnt=0 before the next edge; after rst deasserts, push 1001 -> out_sum=1001 one cycle later.
